intr_nest_ctrl: RTL and testbench

Parametrised nested-interrupt controller between the external interrupt request lines and the CPU's interrupt-entry/uret logic. It latches request edges into pending bits and selects the highest-priority pending interrupt allowed to preempt the one in service. A nesting stack of in-service interrupt numbers is pushed on entry and popped on `uret`. On each valid `uret` it emits the number to clear, replacing the fixed 2-bit single-level clear logic with a depth- and channel-generic block.

---
 rtl/intr_nest_if.sv | 28 ++
 rtl/intr_nest_ctrl.sv | 92 +++++++++
 tb/tb_intr_nest_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/intr_nest_if.sv
// Signal bundle between the interrupt request lines / CPU trap logic and the
// nested-interrupt controller. The controller uses the slave side.
interface intr_nest_if #(
  parameter int N_IRQ = 3,
  parameter int NO_W  = 2,
  parameter int D_W   = 2
);
  logic [N_IRQ-1:0] irq_in;
  logic             ie;
  logic             take_ack;
  logic             uret;
  logic             intr_req;
  logic [NO_W-1:0]  intr_no;
  logic [NO_W-1:0]  cur_no;
  logic [NO_W-1:0]  clr_no;
  logic [D_W-1:0]   depth;
  logic             uret_err;

  modport master (
    output irq_in, ie, take_ack, uret,
    input  intr_req, intr_no, cur_no, clr_no, depth, uret_err
  );

  modport slave (
    input  irq_in, ie, take_ack, uret,
    output intr_req, intr_no, cur_no, clr_no, depth, uret_err
  );
endinterface

// File: rtl/intr_nest_ctrl.sv
// Nested interrupt controller: edge-latched pending bits, highest-number-wins
// preemption against the in-service number, and a push/pop nesting stack.
module intr_nest_ctrl #(
  parameter int N_IRQ = 3,
  parameter int NO_W  = 2,
  parameter int DEPTH = 3,
  parameter int D_W   = 2
) (
  input  logic      clk,
  input  logic      rst,
  intr_nest_if.slave bus
);

  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] take_mask;
  logic [NO_W-1:0]  stack_q [DEPTH];
  logic [NO_W-1:0]  stack_d [DEPTH];
  logic [D_W-1:0]   depth_q, depth_d;
  logic [D_W-1:0]   base_depth;
  logic             uret_err_q, uret_err_d;

  logic [NO_W-1:0]  cand;
  logic [NO_W-1:0]  cur_no;
  logic [NO_W-1:0]  intr_no;
  logic             intr_req;
  logic             take;
  logic             pop;

  assign rise       = bus.irq_in & ~irq_prev_q;
  assign irq_prev_d = bus.irq_in;

  // Later (higher-numbered) channels overwrite earlier ones, so the highest wins.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pend_q[i]) cand = NO_W'(i + 1);
    end
  end

  always_comb begin
    cur_no = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == D_W'(i + 1)) cur_no = stack_q[i];
    end
  end

  assign intr_req = bus.ie & (cand > cur_no) & (depth_q < D_W'(DEPTH));
  assign intr_no  = intr_req ? cand : '0;
  assign take     = bus.take_ack & intr_req;
  assign pop      = bus.uret & (depth_q != '0);

  // A same-cycle pop frees the top slot, so the push lands where the old top was.
  assign base_depth = depth_q - D_W'(pop);
  assign depth_d    = base_depth + D_W'(take);
  assign uret_err_d = uret_err_q | (bus.uret & (depth_q == '0));

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign take_mask[gi] = take & (intr_no == NO_W'(gi + 1));
      assign pend_d[gi]    = (pend_q[gi] & ~take_mask[gi]) | rise[gi];
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
      assign stack_d[gi] = (take && (base_depth == D_W'(gi))) ? intr_no : stack_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      depth_q    <= '0;
      uret_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pend_q     <= pend_d;
      depth_q    <= depth_d;
      uret_err_q <= uret_err_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.intr_req = intr_req;
  assign bus.intr_no  = intr_no;
  assign bus.cur_no   = cur_no;
  assign bus.clr_no   = (pop & ~rst) ? cur_no : '0;
  assign bus.depth    = depth_q;
  assign bus.uret_err = uret_err_q;

endmodule

// File: tb/tb_intr_nest_ctrl.sv
// Directed-vector bench for intr_nest_ctrl with default parameters
// (3 channels, nesting depth 3).
module tb_intr_nest_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  intr_nest_if #(.N_IRQ(3), .NO_W(2), .D_W(2)) bus ();

  intr_nest_ctrl #(.N_IRQ(3), .NO_W(2), .DEPTH(3), .D_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] lines);
    bus.irq_in = lines;
    tick();
    bus.irq_in = '0;
    #1;
    $display("[TB] pulse irq_in=%b", lines);
  endtask

  task automatic take_one();
    bus.take_ack = 1'b1;
    tick();
    bus.take_ack = 1'b0;
    #1;
    $display("[TB] take -> depth=%0d cur_no=%0d", bus.depth, bus.cur_no);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.irq_in = '0; bus.ie = 1'b0; bus.take_ack = 1'b0; bus.uret = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL reset_intr_req got %0d want 0", bus.intr_req); end
    tests_run++; if (bus.intr_no !== 2'd0) begin tests_failed++; $display("FAIL reset_intr_no got %0d want 0", bus.intr_no); end
    tests_run++; if (bus.cur_no !== 2'd0) begin tests_failed++; $display("FAIL reset_cur_no got %0d want 0", bus.cur_no); end
    tests_run++; if (bus.clr_no !== 2'd0) begin tests_failed++; $display("FAIL reset_clr_no got %0d want 0", bus.clr_no); end
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL reset_depth got %0d want 0", bus.depth); end
    tests_run++; if (bus.uret_err !== 1'b0) begin tests_failed++; $display("FAIL reset_uret_err got %0d want 0", bus.uret_err); end
  endtask

  task automatic test_basic();
    bus.ie = 1'b1;
    pulse(3'b001);
    tests_run++; if (bus.intr_req !== 1'b1) begin tests_failed++; $display("FAIL basic_req got %0d want 1", bus.intr_req); end
    tests_run++; if (bus.intr_no !== 2'd1) begin tests_failed++; $display("FAIL basic_no got %0d want 1", bus.intr_no); end
    take_one();
    tests_run++; if (bus.cur_no !== 2'd1) begin tests_failed++; $display("FAIL basic_cur got %0d want 1", bus.cur_no); end
    tests_run++; if (bus.depth !== 2'd1) begin tests_failed++; $display("FAIL basic_depth got %0d want 1", bus.depth); end
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL basic_req_after_take got %0d want 0", bus.intr_req); end
    bus.uret = 1'b1;
    #1;
    tests_run++; if (bus.clr_no !== 2'd1) begin tests_failed++; $display("FAIL basic_clr got %0d want 1", bus.clr_no); end
    tick();
    bus.uret = 1'b0;
    #1;
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL basic_depth_after_uret got %0d want 0", bus.depth); end
    tests_run++; if (bus.cur_no !== 2'd0) begin tests_failed++; $display("FAIL basic_cur_after_uret got %0d want 0", bus.cur_no); end
    tests_run++; if (bus.clr_no !== 2'd0) begin tests_failed++; $display("FAIL basic_clr_pulse got %0d want 0", bus.clr_no); end
  endtask

  task automatic test_nesting();
    pulse(3'b001);
    take_one();
    pulse(3'b100);
    tests_run++; if (bus.intr_no !== 2'd3) begin tests_failed++; $display("FAIL nest_no3 got %0d want 3", bus.intr_no); end
    take_one();
    tests_run++; if (bus.depth !== 2'd2) begin tests_failed++; $display("FAIL nest_depth got %0d want 2", bus.depth); end
    tests_run++; if (bus.cur_no !== 2'd3) begin tests_failed++; $display("FAIL nest_cur got %0d want 3", bus.cur_no); end
    pulse(3'b010);
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL nest_lower_blocked got %0d want 0", bus.intr_req); end
    bus.uret = 1'b1;
    #1;
    tests_run++; if (bus.clr_no !== 2'd3) begin tests_failed++; $display("FAIL nest_clr3 got %0d want 3", bus.clr_no); end
    tick();
    bus.uret = 1'b0;
    #1;
    tests_run++; if (bus.intr_req !== 1'b1) begin tests_failed++; $display("FAIL nest_req2 got %0d want 1", bus.intr_req); end
    tests_run++; if (bus.intr_no !== 2'd2) begin tests_failed++; $display("FAIL nest_no2 got %0d want 2", bus.intr_no); end
    take_one();
    for (int k = 0; k < 2; k++) begin
      bus.uret = 1'b1;
      #1;
      tests_run++; if (bus.clr_no !== 2'(2 - k)) begin tests_failed++; $display("FAIL nest_unwind%0d got %0d want %0d", k, bus.clr_no, 2 - k); end
      tick();
      bus.uret = 1'b0;
      #1;
    end
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL nest_final_depth got %0d want 0", bus.depth); end
  endtask

  task automatic test_simul_ie();
    bus.ie = 1'b0;
    pulse(3'b111);
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL ie_off_cycle%0d got %0d want 0", k, bus.intr_req); end
      tick();
    end
    bus.ie = 1'b1;
    #1;
    tests_run++; if (bus.intr_no !== 2'd3) begin tests_failed++; $display("FAIL ie_on_no got %0d want 3", bus.intr_no); end
    for (int k = 0; k < 3; k++) begin
      take_one();
      bus.uret = 1'b1;
      #1;
      tests_run++; if (bus.clr_no !== 2'(3 - k)) begin tests_failed++; $display("FAIL simul_retire%0d got %0d want %0d", k, bus.clr_no, 3 - k); end
      tick();
      bus.uret = 1'b0;
      #1;
    end
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL simul_drained got %0d want 0", bus.intr_req); end
  endtask

  task automatic test_full_and_err();
    pulse(3'b001); take_one();
    pulse(3'b010); take_one();
    pulse(3'b100); take_one();
    tests_run++; if (bus.depth !== 2'd3) begin tests_failed++; $display("FAIL full_depth got %0d want 3", bus.depth); end
    pulse(3'b001);
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL full_no_req got %0d want 0", bus.intr_req); end
    take_one();
    tests_run++; if (bus.depth !== 2'd3) begin tests_failed++; $display("FAIL full_ignored_take got %0d want 3", bus.depth); end
    for (int k = 0; k < 3; k++) begin
      bus.uret = 1'b1;
      #1;
      tests_run++; if (bus.clr_no !== 2'(3 - k)) begin tests_failed++; $display("FAIL full_unwind%0d got %0d want %0d", k, bus.clr_no, 3 - k); end
      tick();
      bus.uret = 1'b0;
      #1;
    end
    tests_run++; if (bus.intr_no !== 2'd1) begin tests_failed++; $display("FAIL full_waiting1 got %0d want 1", bus.intr_no); end
    bus.uret = 1'b1;
    #1;
    tests_run++; if (bus.clr_no !== 2'd0) begin tests_failed++; $display("FAIL err_clr got %0d want 0", bus.clr_no); end
    tick();
    bus.uret = 1'b0;
    #1;
    tests_run++; if (bus.uret_err !== 1'b1) begin tests_failed++; $display("FAIL err_set got %0d want 1", bus.uret_err); end
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL err_depth got %0d want 0", bus.depth); end
    take_one();
    bus.uret = 1'b1; tick(); bus.uret = 1'b0; #1;
    tests_run++; if (bus.uret_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %0d want 1", bus.uret_err); end
  endtask

  task automatic test_uret_take();
    pulse(3'b001); take_one();
    pulse(3'b010);
    tests_run++; if (bus.intr_no !== 2'd2) begin tests_failed++; $display("FAIL swap_no got %0d want 2", bus.intr_no); end
    bus.uret = 1'b1;
    bus.take_ack = 1'b1;
    #1;
    tests_run++; if (bus.clr_no !== 2'd1) begin tests_failed++; $display("FAIL swap_clr got %0d want 1", bus.clr_no); end
    tick();
    bus.uret = 1'b0;
    bus.take_ack = 1'b0;
    #1;
    tests_run++; if (bus.depth !== 2'd1) begin tests_failed++; $display("FAIL swap_depth got %0d want 1", bus.depth); end
    tests_run++; if (bus.cur_no !== 2'd2) begin tests_failed++; $display("FAIL swap_cur got %0d want 2", bus.cur_no); end
    bus.uret = 1'b1; tick(); bus.uret = 1'b0; #1;
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL swap_drain got %0d want 0", bus.depth); end
  endtask

  task automatic test_reset_mid();
    pulse(3'b001); take_one();
    pulse(3'b010); take_one();
    tests_run++; if (bus.depth !== 2'd2) begin tests_failed++; $display("FAIL rmid_depth_pre got %0d want 2", bus.depth); end
    bus.ie = 1'b0;
    pulse(3'b100);
    rst = 1'b1;
    bus.uret = 1'b1;
    #1;
    tests_run++; if (bus.clr_no !== 2'd0) begin tests_failed++; $display("FAIL rmid_clr_in_rst got %0d want 0", bus.clr_no); end
    tick();
    rst = 1'b0;
    bus.uret = 1'b0;
    bus.ie = 1'b1;
    #1;
    tests_run++; if (bus.depth !== 2'd0) begin tests_failed++; $display("FAIL rmid_depth got %0d want 0", bus.depth); end
    tests_run++; if (bus.cur_no !== 2'd0) begin tests_failed++; $display("FAIL rmid_cur got %0d want 0", bus.cur_no); end
    tests_run++; if (bus.intr_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_req got %0d want 0", bus.intr_req); end
    tests_run++; if (bus.uret_err !== 1'b0) begin tests_failed++; $display("FAIL rmid_err got %0d want 0", bus.uret_err); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.irq_in   = '0;
    bus.ie       = 1'b0;
    bus.take_ack = 1'b0;
    bus.uret     = 1'b0;
    test_reset();
    test_basic();
    test_nesting();
    test_simul_ie();
    test_full_and_err();
    test_uret_take();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
